// File: rtl/lcd_pic_fetch_pkg.sv
// Shared types and constants for the LCD picture fetch path.
// Pixel format, position width and fetch FSM state encodings.
package lcd_pic_fetch_pkg;

  localparam int unsigned RGB_W = 16;
  localparam int unsigned POS_W = 11;

  localparam logic [RGB_W-1:0] COLOR_BLACK = 16'h0000;
  localparam logic [RGB_W-1:0] COLOR_WHITE = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_LOAD = 2'd2
  } fetch_st_e;

endpackage

// File: rtl/lcd_pic_fetch.sv
// Row fetch and pixel shifter between LCD timing driver and pic_ram.
// Ports: sys_clk/sys_rst_n, pixel_xpos/ypos, data_req in; pic_addr,
// pic_q row bus, pixel_data and underrun pulse out.
module lcd_pic_fetch
  import lcd_pic_fetch_pkg::*;
#(
  parameter logic [POS_W-1:0] PIC_X0   = 11'd8,
  parameter logic [POS_W-1:0] PIC_Y0   = 11'd0,
  parameter int unsigned      PIC_W    = 200,
  parameter int unsigned      PIC_H    = 10,
  parameter logic [RGB_W-1:0] BG_COLOR = COLOR_BLACK
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic [POS_W-1:0]       pixel_xpos,
  input  logic [POS_W-1:0]       pixel_ypos,
  input  logic                   data_req,
  output logic [8:0]             pic_addr,
  input  logic [PIC_W*RGB_W:0]   pic_q,
  output logic [RGB_W-1:0]       pixel_data,
  output logic                   underrun
);

  localparam int unsigned ROW_W = PIC_W * RGB_W;

  // Window edges widened to 12 bits so the right/bottom edge never wraps.
  localparam logic [11:0] X_LO = {1'b0, PIC_X0};
  localparam logic [11:0] X_HI = X_LO + 12'(PIC_W);
  localparam logic [11:0] Y_LO = {1'b0, PIC_Y0};
  localparam logic [11:0] Y_HI = Y_LO + 12'(PIC_H);

  fetch_st_e        state_q;
  logic [POS_W-1:0] y_last_q;
  logic             row_ok_q;
  logic [ROW_W-1:0] row_buf_q;
  logic [8:0]       pic_addr_q;
  logic [RGB_W-1:0] pixel_data_q;
  logic             underrun_q;

  logic [11:0]      x12;
  logic [11:0]      y12;
  logic             y_in_win;
  logic             in_win;
  logic             line_chg;
  logic [POS_W-1:0] ydiff;
  logic [2:0]       unused_bits;

  assign x12      = {1'b0, pixel_xpos};
  assign y12      = {1'b0, pixel_ypos};
  assign y_in_win = (y12 >= Y_LO) && (y12 < Y_HI);
  assign in_win   = y_in_win && (x12 >= X_LO) && (x12 < X_HI);
  assign line_chg = (pixel_ypos != y_last_q);
  assign ydiff    = pixel_ypos - PIC_Y0;

  assign unused_bits = {pic_q[ROW_W], ydiff[POS_W-1:9]};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ST_IDLE;
      y_last_q     <= '1;
      row_ok_q     <= 1'b0;
      row_buf_q    <= '0;
      pic_addr_q   <= '0;
      pixel_data_q <= '0;
      underrun_q   <= 1'b0;
    end else begin
      y_last_q <= pixel_ypos;

      // A new line always aborts any fetch in flight.
      if (line_chg) begin
        row_ok_q <= 1'b0;
        if (y_in_win) begin
          pic_addr_q <= ydiff[8:0];
          state_q    <= ST_ADDR;
        end else begin
          state_q <= ST_IDLE;
        end
      end else begin
        unique case (state_q)
          ST_ADDR: state_q <= ST_LOAD;
          ST_LOAD: begin
            row_buf_q <= pic_q[ROW_W-1:0];
            row_ok_q  <= 1'b1;
            state_q   <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end

      underrun_q <= 1'b0;
      if (data_req) begin
        if (!in_win) begin
          pixel_data_q <= BG_COLOR;
        end else if (row_ok_q) begin
          pixel_data_q <= row_buf_q[ROW_W-1 -: RGB_W];
          row_buf_q    <= row_buf_q << RGB_W;
        end else begin
          pixel_data_q <= BG_COLOR;
          underrun_q   <= 1'b1;
        end
      end
    end
  end

  assign pic_addr   = pic_addr_q;
  assign pixel_data = pixel_data_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_lcd_pic_fetch.sv
// Directed bench for lcd_pic_fetch with a behavioural pic_ram.
// Row r pixel k reads back as {r[6:0], k[8:0]}.
module tb_lcd_pic_fetch;

  localparam int PW = 200;

  logic              clk;
  logic              rst_n;
  logic [10:0]       xpos;
  logic [10:0]       ypos;
  logic              req;
  logic [8:0]        addr;
  logic [PW*16:0]    q;
  logic [15:0]       pix;
  logic              ur;

  int total;
  int bad;

  lcd_pic_fetch dut (
    .sys_clk    (clk),
    .sys_rst_n  (rst_n),
    .pixel_xpos (xpos),
    .pixel_ypos (ypos),
    .data_req   (req),
    .pic_addr   (addr),
    .pic_q      (q),
    .pixel_data (pix),
    .underrun   (ur)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ROM; the spare top bit is set to prove it is ignored.
  always_comb begin
    q = '0;
    q[PW*16] = 1'b1;
    for (int k = 0; k < PW; k++) begin
      q[PW*16-1-16*k -: 16] = {addr[6:0], 9'(k)};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_pix(input int y, input int x);
    logic [6:0] yr;
    logic [8:0] k;
    yr = 7'(y);
    k  = 9'(x - 8);
    if (y < 10 && x >= 8 && x < 208) return {yr, k};
    return 16'h0000;
  endfunction

  // Request columns xs..xe of line y back to back and check every pixel.
  task automatic stream(input int y, input int xs, input int xe);
    int n_ur;
    n_ur = 0;
    for (int x = xs; x <= xe; x++) begin
      ypos = 11'(y);
      xpos = 11'(x);
      req  = 1'b1;
      step();
      chk($sformatf("pix_y%0d_x%0d", y, x), 32'(pix), 32'(exp_pix(y, x)));
      if (ur) n_ur++;
    end
    req = 1'b0;
    chk($sformatf("no_underrun_y%0d", y), 32'(n_ur), 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    xpos  = '0;
    ypos  = '0;
    req   = 1'b0;

    #2;
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_pix", 32'(pix), 32'd0);
    chk("rst_ur", 32'(ur), 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // 1: steady line 0 after release; fetch triggered by y_last reset value
    step();
    step();
    step();
    chk("t1_addr", 32'(addr), 32'd0);
    chk("t1_pix", 32'(pix), 32'd0);
    chk("t1_ur", 32'(ur), 32'd0);

    // 2: full line 0
    stream(0, 0, 239);

    // 3: last picture row, then first line below the picture
    stream(9, 0, 239);
    stream(10, 0, 239);
    chk("t3_addr_hold", 32'(addr), 32'd9);

    // 4: request one cycle after a line change -> underrun
    ypos = 11'd2;
    xpos = 11'd0;
    step();
    xpos = 11'd8;
    req  = 1'b1;
    step();
    chk("t4_pix_bg", 32'(pix), 32'd0);
    chk("t4_ur_hi", 32'(ur), 32'd1);
    req = 1'b0;
    step();
    chk("t4_ur_lo", 32'(ur), 32'd0);
    step();
    xpos = 11'd9;
    req  = 1'b1;
    step();
    chk("t4_unshifted", 32'(pix), 32'h0400);
    chk("t4_ur_after", 32'(ur), 32'd0);
    req = 1'b0;

    // 5: back-to-back line changes restart the fetch
    ypos = 11'd3;
    xpos = 11'd0;
    step();
    step();
    step();
    step();
    ypos = 11'd4;
    step();
    chk("t5_addr4", 32'(addr), 32'd4);
    ypos = 11'd5;
    step();
    chk("t5_addr5", 32'(addr), 32'd5);
    step();
    xpos = 11'd8;
    req  = 1'b1;
    step();
    chk("t5_not_ready", 32'(ur), 32'd1);
    step();
    chk("t5_ready_ur", 32'(ur), 32'd0);
    chk("t5_px0", 32'(pix), 32'h0A00);
    stream(5, 9, 239);

    // 6: reset mid-line, then a fresh full line
    stream(6, 0, 100);
    chk("t6_pre_pix", 32'(pix), 32'(exp_pix(6, 100)));
    rst_n = 1'b0;
    #1;
    chk("t6_rst_pix", 32'(pix), 32'd0);
    chk("t6_rst_addr", 32'(addr), 32'd0);
    chk("t6_rst_ur", 32'(ur), 32'd0);
    step();
    rst_n = 1'b1;
    stream(7, 0, 239);
    chk("t6_addr", 32'(addr), 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
